// File: rtl/pipeline_pkg.sv
// Shared pipeline types: M-extension op encoding, mul/div FSM states and op decode helpers.
package pipeline_pkg;

   localparam int XLEN = 64;

   typedef enum logic [3:0] {
      MUL    = 4'd0,
      MULH   = 4'd1,
      MULHSU = 4'd2,
      MULHU  = 4'd3,
      DIV    = 4'd4,
      DIVU   = 4'd5,
      REM    = 4'd6,
      REMU   = 4'd7,
      MULW   = 4'd8,
      DIVW   = 4'd9,
      DIVUW  = 4'd10,
      REMW   = 4'd11,
      REMUW  = 4'd12
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } muldiv_state_e;

   function automatic logic is_w(input muldiv_op_t op);
      return op inside {MULW, DIVW, DIVUW, REMW, REMUW};
   endfunction

   function automatic logic is_div(input muldiv_op_t op);
      return op inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
   endfunction

   function automatic logic is_rem(input muldiv_op_t op);
      return op inside {REM, REMU, REMW, REMUW};
   endfunction

   function automatic logic is_mulh(input muldiv_op_t op);
      return op inside {MULH, MULHSU, MULHU};
   endfunction

   // rs2_sel picks the operand: MULHSU treats rs1 as signed and rs2 as unsigned.
   function automatic logic is_signed(input muldiv_op_t op, input logic rs2_sel);
      logic s;
      s = 1'b0;
      unique case (op)
         MUL, MULH, DIV, REM, MULW, DIVW, REMW: s = 1'b1;
         MULHSU:                                s = ~rs2_sel;
         default:                               s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
   parameter int XLEN = 64
) (
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            bit_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [2*XLEN-1:0] acc_sh;
   logic [2*XLEN-1:0] acc_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN-1:0]   diff;
   logic              ge;

   always_comb begin
      // Multiply: {hi,lo} is the MSB-first accumulator, bit_i is the current multiplier bit.
      acc_sh  = {hi_i[XLEN-2:0], lo_i, 1'b0};
      acc_sum = acc_sh + {{XLEN{1'b0}}, (bit_i ? a_i : {XLEN{1'b0}})};
      // Divide: hi is the partial remainder, lo collects quotient bits, bit_i is the next dividend bit.
      rem_sh  = {hi_i, bit_i};
      ge      = rem_sh >= {1'b0, b_i};
      diff    = rem_sh[XLEN-1:0] - b_i;
      if (is_div_i) begin
         hi_o = ge ? diff : rem_sh[XLEN-1:0];
         lo_o = {lo_i[XLEN-2:0], ge};
      end else begin
         hi_o = acc_sum[2*XLEN-1:XLEN];
         lo_o = acc_sum[XLEN-1:0];
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the EX stage; stalls ID/EX while iterating
// and presents each result for one DONE cycle (longer under hold_i).
module ex_muldiv
   import pipeline_pkg::*;
#(
   parameter int XLEN = pipeline_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            hold_i,
   input  logic            start_i,
   input  muldiv_op_t      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   localparam int H  = XLEN / 2;
   localparam int CW = $clog2(XLEN);

   muldiv_state_e   state_q, state_d;
   muldiv_op_t      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            neg_q, neg_d, negr_q, negr_d;
   logic [4:0]      tag_q, tag_d, rd_q, rd_d;

   logic            in_w, in_div, sa, sb, div0, ovf;
   logic [XLEN-1:0] a_ext, b_ext, min_val, spec_res;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0] quot_s, rem_s, fix_res;
   logic            q_div, step_bit;
   logic [XLEN-1:0] step_hi, step_lo;

   assign q_div    = is_div(op_q);
   assign step_bit = q_div ? a_q[cnt_q] : b_q[cnt_q];

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div_i (q_div),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .bit_i    (step_bit),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   // Operand conditioning and special-case results for the op being offered in IDLE.
   always_comb begin
      in_w   = is_w(op_i);
      in_div = is_div(op_i);
      a_ext  = rs1_i;
      b_ext  = rs2_i;
      if (in_w) begin
         a_ext = is_signed(op_i, 1'b0) ? {{H{rs1_i[H-1]}}, rs1_i[H-1:0]} : {{H{1'b0}}, rs1_i[H-1:0]};
         b_ext = is_signed(op_i, 1'b1) ? {{H{rs2_i[H-1]}}, rs2_i[H-1:0]} : {{H{1'b0}}, rs2_i[H-1:0]};
      end
      sa      = is_signed(op_i, 1'b0) & a_ext[XLEN-1];
      sb      = is_signed(op_i, 1'b1) & b_ext[XLEN-1];
      min_val = in_w ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      div0    = in_div & (b_ext == '0);
      ovf     = in_div & is_signed(op_i, 1'b0) & (a_ext == min_val) & (b_ext == '1);
      if (div0) spec_res = is_rem(op_i) ? a_ext : '1;
      else      spec_res = is_rem(op_i) ? '0 : a_ext;
      if (in_w) spec_res = {{H{spec_res[H-1]}}, spec_res[H-1:0]};
   end

   // Sign fixup of the unsigned magnitude result; remainder takes the dividend's sign.
   always_comb begin
      prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      quot_s = neg_q ? -lo_q : lo_q;
      rem_s  = negr_q ? -hi_q : hi_q;
      if (q_div)              fix_res = is_rem(op_q) ? rem_s : quot_s;
      else if (is_mulh(op_q)) fix_res = prod_s[2*XLEN-1:XLEN];
      else                    fix_res = prod_s[XLEN-1:0];
      if (is_w(op_q)) fix_res = {{H{fix_res[H-1]}}, fix_res[H-1:0]};
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      negr_d  = negr_q;
      tag_d   = tag_q;
      rd_d    = rd_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               op_d   = op_i;
               a_d    = sa ? -a_ext : a_ext;
               b_d    = sb ? -b_ext : b_ext;
               hi_d   = '0;
               lo_d   = '0;
               neg_d  = sa ^ sb;
               negr_d = sa;
               tag_d  = rd_i;
               cnt_d  = in_w ? CW'(H - 1) : CW'(XLEN - 1);
               if (div0 || ovf) begin
                  res_d   = spec_res;
                  rd_d    = rd_i;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = FIXUP;
         end
         FIXUP: begin
            res_d   = fix_res;
            rd_d    = tag_q;
            state_d = DONE;
         end
         DONE: begin
            if (!hold_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A flush abandons the op and must not disturb the retired result.
      if (flush_i) begin
         state_d = IDLE;
         res_d   = res_q;
         rd_d    = rd_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         op_q    <= MUL;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         negr_q  <= 1'b0;
         tag_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         negr_q  <= negr_d;
         tag_q   <= tag_d;
         rd_q    <= rd_d;
      end
   end

   // Stall is combinational so ID/EX advances in the same cycle the result retires.
   assign stall_o  = rst_ni & (((state_q == IDLE) & start_i & ~flush_i) |
                               (state_q == CALC) | (state_q == FIXUP) |
                               ((state_q == DONE) & hold_i));
   assign done_o   = (state_q == DONE);
   assign result_o = res_q;
   assign rd_o     = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed ops push expected results, a monitor checks each retire.
module tb_ex_muldiv;
   import pipeline_pkg::*;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b1;
   logic         flush_i = 1'b0;
   logic         hold_i = 1'b0;
   logic         start_i = 1'b0;
   muldiv_op_t   op_i = MUL;
   logic [63:0]  rs1_i = '0;
   logic [63:0]  rs2_i = '0;
   logic [4:0]   rd_i = '0;
   logic         stall_o, done_o;
   logic [63:0]  result_o;
   logic [4:0]   rd_o;

   ex_muldiv #(.XLEN(64)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .hold_i(hold_i),
      .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
      .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   done_count = 0;
   logic done_prev = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, expv);
   endtask

   // Monitor: one scoreboard pop per retired result (rising done_o).
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         done_prev = 1'b0;
      end else begin
         if (done_o && !done_prev) begin
            exp_t e;
            done_count++;
            if (sb_q.size() == 0) begin
               check("unexpected_done", 64'(result_o), 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
               e = sb_q.pop_front();
               check("result", result_o, e.res);
               check("rd", 64'(rd_o), 64'(e.rd));
               check("latency_cycle", 64'(cyc), 64'(e.cyc));
               $display("retire op rd=%0d result=0x%016h cycle=%0d", rd_o, result_o, cyc);
            end
         end
         done_prev = done_o;
      end
   end

   // Caller is #1 after a posedge; that cycle is cycle 0 of the op.
   task automatic run_op(input muldiv_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] expv, input int lat,
                         input int hold_n);
      exp_t e;
      int   n_done = 0;
      int   n_stable = 0;
      int   n_stall_ok = 0;
      e.res = expv;
      e.rd  = rd;
      e.cyc = cyc + lat;
      sb_q.push_back(e);
      start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
      for (int c = 0; c <= lat + hold_n; c++) begin
         if (c > 0) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            hold_i  = (c >= lat) && (c < lat + hold_n);
         end
         @(negedge clk_i);
         if ((c < lat + hold_n) == stall_o) n_stall_ok++;
         if (done_o) begin
            n_done++;
            if (result_o == expv && rd_o == rd) n_stable++;
         end
      end
      check("stall_profile", 64'(n_stall_ok), 64'(lat + hold_n + 1));
      check("done_cycles", 64'(n_done), 64'(hold_n + 1));
      check("done_stable", 64'(n_stable), 64'(hold_n + 1));
      @(posedge clk_i); #1;
      hold_i = 1'b0;
      start_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      #1 rst_ni = 1'b0;
      #2;
      check("reset_done", 64'(done_o), 64'd0);
      check("reset_stall", 64'(stall_o), 64'd0);
      check("reset_result", result_o, 64'd0);
      check("reset_rd", 64'(rd_o), 64'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i) rst_ni = 1'b1;
      @(posedge clk_i); #1;

      run_op(MUL,    64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 64'hFFFF_FFFF_FFFF_FFF4, 66, 0);
      run_op(MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
             64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
      run_op(DIV,    64'd7, 64'd0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      run_op(REM,    64'd7, 64'd0, 5'd4, 64'd7, 1, 0);
      run_op(DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5,
             64'h8000_0000_0000_0000, 1, 0);
      run_op(REMW,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
      run_op(DIV,    64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd7, 64'hFFFF_FFFF_FFFF_FFFA, 66, 0);
      run_op(REM,    64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd8, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
      run_op(MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'd0, 66, 0);
      run_op(MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11,
             64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
      run_op(MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
      run_op(DIVUW,  64'h1234_5678_FFFF_FFFF, 64'd1, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
      run_op(REMU,   64'd100, 64'd7, 5'd14, 64'd2, 66, 0);
      run_op(DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd15,
             64'hFFFF_FFFF_8000_0000, 1, 0);
      run_op(REMUW,  64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 5'd16,
             64'hFFFF_FFFF_8000_0001, 1, 0);

      // Flush mid-divide: back in IDLE in cycle 21, and the op never retires.
      dc = done_count;
      start_i = 1'b1; op_i = DIVU; rs1_i = 64'd100; rs2_i = 64'd7; rd_i = 5'd17;
      @(posedge clk_i); #1 start_i = 1'b0;
      repeat (18) @(posedge clk_i);
      @(posedge clk_i); #1 flush_i = 1'b1;
      @(posedge clk_i); #1 flush_i = 1'b0;
      @(negedge clk_i);
      check("flush_idle_stall", 64'(stall_o), 64'd0);
      check("flush_idle_done", 64'(done_o), 64'd0);
      repeat (60) @(posedge clk_i);
      check("flush_no_done", 64'(done_count), 64'(dc));
      #1;
      // Flush in the same cycle as start_i: op is refused.
      start_i = 1'b1; flush_i = 1'b1; op_i = DIV; rs1_i = 64'd1; rs2_i = 64'd1; rd_i = 5'd18;
      @(negedge clk_i);
      check("flush_beats_start_stall", 64'(stall_o), 64'd0);
      @(posedge clk_i); #1 start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk_i);
      check("flush_beats_start_idle", 64'(stall_o), 64'd0);
      @(posedge clk_i); #1;
      run_op(DIVU, 64'd100, 64'd7, 5'd19, 64'd14, 66, 0);

      // Asynchronous reset mid-CALC clears outputs at once and discards the op.
      dc = done_count;
      start_i = 1'b1; op_i = MUL; rs1_i = 64'd5; rs2_i = 64'd5; rd_i = 5'd20;
      @(posedge clk_i); #1 start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check("midop_reset_result", result_o, 64'd0);
      check("midop_reset_rd", 64'(rd_o), 64'd0);
      check("midop_reset_stall", 64'(stall_o), 64'd0);
      check("midop_reset_done", 64'(done_o), 64'd0);
      @(negedge clk_i) rst_ni = 1'b1;
      repeat (80) @(posedge clk_i);
      check("reset_no_done", 64'(done_count), 64'(dc));
      #1;

      // Hold in DONE for 3 cycles: done/result stable 4 cycles, stall high 3.
      run_op(MUL, 64'd6, 64'd7, 5'd9, 64'd42, 66, 3);
      run_op(MULW, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd21, 64'hFFFF_FFFF_FFFF_FFF1, 34, 0);

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
